// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock/reset generator: FSM states and the
// half-period helper used to place the falling edge of cpu_clk.
package cpu_clk_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      IDLE = 2'd2,
      STEP = 2'd3
   } state_t;

   function automatic int halfPeriod(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/cpu_clk_gen_if.sv
// Bundles the mode/button inputs and the generated CPU clock, enable,
// reset and step counter into one port group.
interface cpu_clk_gen_if #(
   parameter int CNT_W = 16
);
   logic             step_mode;
   logic             step_btn;
   logic             cpu_clk;
   logic             cpu_ce;
   logic             cpu_rst_n;
   logic [CNT_W-1:0] step_cnt;

   modport master (
      output step_mode, step_btn,
      input  cpu_clk, cpu_ce, cpu_rst_n, step_cnt
   );

   modport slave (
      input  step_mode, step_btn,
      output cpu_clk, cpu_ce, cpu_rst_n, step_cnt
   );
endinterface

// File: rtl/cpu_clk_gen_btn_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability counter, and a
// one-cycle pulse whenever the accepted level rises.
module btn_debounce #(
   parameter int DEB_CYCLES = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);
   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_rise;

   // The level is accepted once the sample has disagreed with it for DEB_CYCLES+1 samples in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         r_rise <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
            r_rise  <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_rise = r_rise;
endmodule

// File: rtl/cpu_clk_gen.sv
// CPU clock/reset generator: reset synchroniser with stretched release,
// divided 50% clock with aligned enable, and a free-run/single-step FSM.
import cpu_clk_pkg::*;

module cpu_clk_gen #(
   parameter int DIV        = 4,
   parameter int RST_HOLD   = 16,
   parameter int DEB_CYCLES = 2000000,
   parameter int CNT_W      = 16
) (
   input  logic          clk,
   input  logic          rst,
   cpu_clk_gen_if.slave  bus
);
   localparam int            CW       = $clog2(DIV);
   localparam int            HALF     = halfPeriod(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
   localparam int            HW       = $clog2(RST_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_rst_sync;
   logic [1:0]       r_mode_sync;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic [CW-1:0]    w_cnt_wrap;
   logic [HW-1:0]    r_hold;
   logic [HW-1:0]    w_hold_next;
   logic             r_pending;
   logic             w_pending_next;
   logic             w_step_done;
   logic             w_release;
   logic             w_rise;
   logic             r_cpu_clk;
   logic             r_cpu_ce;
   logic             r_cpu_rst_n;
   logic [CNT_W-1:0] r_step_cnt;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst),
      .i_btn  (bus.step_btn),
      .o_rise (w_rise)
   );

   assign w_cnt_wrap = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

   // Parking always leaves cnt at DIV-1, so leaving IDLE restarts a clean period at cnt=0.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = w_cnt_wrap;
      w_hold_next    = r_hold;
      w_pending_next = r_pending;
      w_step_done    = 1'b0;
      w_release      = 1'b0;
      case (r_state)
         HOLD: begin
            if (r_rst_sync[1] && (r_hold != HOLD_MAX))
               w_hold_next = r_hold + 1'b1;
            if ((w_hold_next == HOLD_MAX) && (w_cnt_wrap == '0)) begin
               w_release    = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if ((r_cnt == CNT_LAST) && r_mode_sync[1]) begin
               w_state_next = IDLE;
               w_cnt_next   = CNT_LAST;
            end
         end
         IDLE: begin
            w_cnt_next = CNT_LAST;
            if (r_pending) begin
               w_state_next = STEP;
               w_cnt_next   = '0;
            end else if (!r_mode_sync[1]) begin
               w_state_next = RUN;
               w_cnt_next   = '0;
            end else if (w_rise) begin
               w_pending_next = 1'b1;
            end
         end
         STEP: begin
            if (r_cnt == CNT_LAST) begin
               w_state_next   = IDLE;
               w_cnt_next     = CNT_LAST;
               w_pending_next = 1'b0;
               w_step_done    = 1'b1;
            end
         end
         default: begin
            w_state_next = HOLD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= HOLD;
         r_rst_sync  <= '0;
         r_mode_sync <= '0;
         r_cnt       <= CNT_LAST;
         r_hold      <= '0;
         r_pending   <= 1'b0;
         r_cpu_clk   <= 1'b0;
         r_cpu_ce    <= 1'b0;
         r_cpu_rst_n <= 1'b0;
         r_step_cnt  <= '0;
      end else begin
         r_rst_sync  <= {r_rst_sync[0], 1'b1};
         r_mode_sync <= {r_mode_sync[0], bus.step_mode};
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_hold      <= w_hold_next;
         r_pending   <= w_pending_next;
         r_cpu_ce    <= (w_cnt_next == '0);
         if (w_cnt_next == '0)
            r_cpu_clk <= 1'b1;
         else if (w_cnt_next == CNT_HALF)
            r_cpu_clk <= 1'b0;
         if (w_release)
            r_cpu_rst_n <= 1'b1;
         if (w_step_done)
            r_step_cnt <= r_step_cnt + 1'b1;
      end
   end

   assign bus.cpu_clk   = r_cpu_clk;
   assign bus.cpu_ce    = r_cpu_ce;
   assign bus.cpu_rst_n = r_cpu_rst_n;
   assign bus.step_cnt  = r_step_cnt;
endmodule

// File: tb/tb_cpu_clk_gen.sv
// Randomised scoreboard bench for cpu_clk_gen: a monitor checks clock phases
// and pops expected step counts; stimulus tasks check latencies and quiet periods.
module tb_cpu_clk_gen;
   localparam int DIV           = 4;
   localparam int RST_HOLD      = 8;
   localparam int DEB           = 4;
   localparam int CNT_W         = 2;
   localparam int HALF          = DIV / 2;
   localparam int WRAP          = 1 << CNT_W;
   localparam int PRESS_TO_RISE = (DEB + 3) + 2;
   localparam int MODE_EXIT_LAT = 2 + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   cpu_clk_gen_if #(.CNT_W(CNT_W)) bus ();

   cpu_clk_gen #(
      .DIV        (DIV),
      .RST_HOLD   (RST_HOLD),
      .DEB_CYCLES (DEB),
      .CNT_W      (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   int checks     = 0;
   int failures   = 0;
   int modelCount = 0;
   int expQ[$];
   bit monOn      = 1'b0;
   bit stepWatch  = 1'b0;
   bit expActive  = 1'b0;
   int expVal     = 0;
   int expDue     = 0;
   bit prevClk    = 1'b0;
   bit lowValid   = 1'b0;
   int highLen    = 0;
   int lowLen     = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d..%0d (t=%0t)", name, actual, lo, hi, $time);
      end
   endtask

   task automatic applyStimulus(input logic mode, input logic btn);
      bus.step_mode = mode;
      bus.step_btn  = btn;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic countCe(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.cpu_ce) cnt++;
      end
   endtask

   task automatic waitCe(input int maxN, output int lat);
      lat = -1;
      for (int i = 1; i <= maxN; i++) begin
         @(negedge clk);
         if (bus.cpu_ce) begin
            lat = i;
            break;
         end
      end
   endtask

   // Monitor: phase lengths, enable alignment, and the step-count scoreboard.
   always @(negedge clk) begin
      if (monOn) begin
         if (bus.cpu_clk && !prevClk) begin
            checkOutput("ce_on_rise", bus.cpu_ce, 1);
            if (lowValid) checkRange("low_phase", lowLen, HALF, 1 << 30);
            highLen = 1;
            if (stepWatch) begin
               checkOutput("period_expected", expQ.size() > 0, 1);
               if (expQ.size() > 0) begin
                  expVal    = expQ.pop_front();
                  expDue    = cyc + DIV;
                  expActive = 1'b1;
               end
            end
         end else begin
            checkOutput("ce_outside_rise", bus.cpu_ce, 0);
            if (!bus.cpu_clk && prevClk) begin
               checkOutput("high_phase", highLen, HALF);
               lowLen   = 1;
               lowValid = 1'b1;
            end else if (bus.cpu_clk) begin
               highLen++;
            end else begin
               lowLen++;
            end
         end
         if (expActive && cyc == expDue - 1)
            checkOutput("step_cnt_before_end", bus.step_cnt, (expVal + WRAP - 1) % WRAP);
         if (expActive && cyc == expDue) begin
            checkOutput("step_cnt_after_step", bus.step_cnt, expVal);
            expActive = 1'b0;
         end
         prevClk = bus.cpu_clk;
      end else begin
         prevClk   = 1'b0;
         lowValid  = 1'b0;
         expActive = 1'b0;
      end
   end

   task automatic releaseFromReset();
      bit risen;
      risen     = 1'b0;
      stepWatch = 1'b0;
      expQ.delete();
      modelCount = 0;
      @(negedge clk);
      rst   = 1'b1;
      monOn = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k <= DIV)
            checkOutput($sformatf("release_clk_c%0d", k), bus.cpu_clk, (k <= HALF) ? 1 : 0);
         if (!risen && bus.cpu_rst_n) begin
            risen = 1'b1;
            checkRange("rst_release_cycle", k, RST_HOLD + 2, RST_HOLD + 1 + DIV);
            checkOutput("rst_release_on_ce", bus.cpu_ce, 1);
         end
      end
      checkOutput("rst_released", risen, 1);
   endtask

   task automatic enterStepMode();
      int lat;
      int n;
      waitCe(2 * DIV, lat);
      checkRange("free_run_before_step", lat, 1, DIV);
      applyStimulus(1'b1, bus.step_btn);
      tick(3 * DIV);
      stepWatch = 1'b1;
      countCe(20, n);
      checkOutput("parked_no_periods", n, 0);
      checkOutput("parked_clk_low", bus.cpu_clk, 0);
   endtask

   task automatic cleanStep(input int hold);
      int lat;
      int n;
      lat = -1;
      n   = 0;
      modelCount = (modelCount + 1) % WRAP;
      expQ.push_back(modelCount);
      applyStimulus(1'b1, 1'b1);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == hold) applyStimulus(1'b1, 1'b0);
         if (bus.cpu_ce) begin
            n++;
            if (lat < 0) lat = i;
         end
      end
      checkOutput("press_to_rise", lat, PRESS_TO_RISE);
      checkOutput("periods_per_press", n, 1);
   endtask

   task automatic bounce();
      int n;
      int elapsed;
      int w;
      bit lvl;
      elapsed = 0;
      lvl     = 1'b1;
      while (elapsed < 20) begin
         w = $urandom_range(1, DEB);
         applyStimulus(1'b1, lvl);
         tick(w);
         elapsed += w;
         lvl = ~lvl;
      end
      applyStimulus(1'b1, 1'b0);
      countCe(40, n);
      checkOutput("bounce_no_period", n, 0);
      checkOutput("bounce_step_cnt", bus.step_cnt, modelCount);
   endtask

   task automatic pressInRun();
      applyStimulus(1'b0, 1'b1);
      tick(8);
      applyStimulus(1'b0, 1'b0);
      tick(20);
   endtask

   task automatic exitStepMode();
      int lat;
      stepWatch = 1'b0;
      applyStimulus(1'b0, 1'b0);
      waitCe(4 * DIV, lat);
      checkOutput("mode_exit_latency", lat, MODE_EXIT_LAT);
   endtask

   task automatic resetMidStep();
      int lat;
      int n;
      expQ.push_back((modelCount + 1) % WRAP);
      applyStimulus(1'b1, 1'b1);
      waitCe(20, lat);
      checkOutput("press_to_rise_before_reset", lat, PRESS_TO_RISE);
      @(negedge clk);
      monOn = 1'b0;
      rst   = 1'b0;
      #1;
      checkOutput("reset_cpu_rst_n", bus.cpu_rst_n, 0);
      checkOutput("reset_cpu_clk", bus.cpu_clk, 0);
      checkOutput("reset_step_cnt", bus.step_cnt, 0);
      tick(3);
      releaseFromReset();
      tick(4);
      applyStimulus(1'b1, 1'b0);
      tick(DEB + 8);
      stepWatch = 1'b1;
      countCe(30, n);
      checkOutput("held_press_in_hold_discarded", n, 0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
      tick(3);
      checkOutput("rst_cpu_clk", bus.cpu_clk, 0);
      checkOutput("rst_cpu_ce", bus.cpu_ce, 0);
      checkOutput("rst_cpu_rst_n", bus.cpu_rst_n, 0);
      checkOutput("rst_step_cnt", bus.step_cnt, 0);

      releaseFromReset();
      tick($urandom_range(5, 20));

      pressInRun();
      enterStepMode();
      checkOutput("run_press_discarded", bus.step_cnt, 0);

      cleanStep(10);
      tick($urandom_range(2, 8));
      bounce();

      for (int s = 0; s < 4; s++) begin
         cleanStep($urandom_range(DEB + 2, 12));
         tick($urandom_range(2, 10));
      end

      exitStepMode();
      tick($urandom_range(8, 24));

      enterStepMode();
      resetMidStep();
      cleanStep($urandom_range(DEB + 2, 12));
      tick(DIV * 2);

      checkOutput("scoreboard_drained", expQ.size(), 0);
      checkOutput("cpu_rst_n_final", bus.cpu_rst_n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog simulation did not finish, actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
